// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The optional watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } state_e;

    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned STREAK_W    = 4;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned TO_W        = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the unified memory (slave).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    logic          mack;

    modport master (
        output mreq,
        output mwe,
        output maddr,
        output mwdata,
        input  mrdata,
        input  mack
    );

    modport slave (
        input  mreq,
        input  mwe,
        input  maddr,
        input  mwdata,
        output mrdata,
        output mack
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: flags a transaction that never sees mack and holds err until reset.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic mack,
    output logic expire,
    output logic err
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Fires in the TIMEOUT-th busy cycle; a mack in that same cycle still wins.
    assign expire = busy && !mack && (cnt_q == CntW'(TIMEOUT - 1));
    assign err    = err_q;

    always_comb begin
        cnt_d = '0;
        err_d = err_q | expire;
        if (busy && !mack && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between fetch and data ports; data has priority with a
// starvation guard for fetch. Optional watchdog under MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ireq,
    input  logic [AW-1:0]       iaddr,
    output logic                iready,
    output logic [DW-1:0]       irdata,
    input  logic                dreq,
    input  logic                dwe,
    input  logic [AW-1:0]       daddr,
    input  logic [DW-1:0]       dwdata,
    output logic                dready,
    output logic [DW-1:0]       drdata,
    mem_arbiter_if.master       mem,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                err
);
    localparam logic [STREAK_W-1:0] StarveLim = STREAK_W'(STARVE_MAX);

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] dstreak_q, dstreak_d;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;
    logic                we_q;
    logic                grant_i, grant_d;
    logic                expire;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (state_q != IDLE),
        .mack   (mem.mack),
        .expire (expire),
        .err    (err)
    );
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        iready  = 1'b0;
        dready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!err) begin
                    if (dreq && !(ireq && dstreak_q == StarveLim)) begin
                        grant_d = 1'b1;
                    end else if (ireq) begin
                        grant_i = 1'b1;
                    end
                end
            end
            IBUSY: begin
                if (mem.mack) begin
                    iready  = 1'b1;
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            DBUSY: begin
                if (mem.mack) begin
                    dready  = 1'b1;
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_d) begin
            state_d = DBUSY;
        end else if (grant_i) begin
            state_d = IBUSY;
        end
    end

    // Streak counts data wins that made a waiting fetch wait; saturates at the limit.
    always_comb begin
        dstreak_d = dstreak_q;
        if (grant_i || (state_q == IDLE && !ireq)) begin
            dstreak_d = '0;
        end else if (grant_d && ireq && dstreak_q != StarveLim) begin
            dstreak_d = dstreak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            if (grant_d) begin
                addr_q  <= daddr;
                wdata_q <= dwdata;
                we_q    <= dwe;
            end else if (grant_i) begin
                addr_q  <= iaddr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end
        end
    end

    assign mem.mreq   = (state_q != IDLE);
    assign mem.mwe    = we_q;
    assign mem.maddr  = addr_q;
    assign mem.mwdata = wdata_q;
    assign irdata     = mem.mrdata;
    assign drdata     = mem.mrdata;
    assign stall_if   = ireq && !iready;
    assign stall_mem  = dreq && !dready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; build with MEM_ARB_TIMEOUT_EN to cover the watchdog.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        iready, dready, stall_if, stall_mem, err;
    logic [31:0] irdata, drdata;

    int n_checks;
    int n_fail;

    mem_arbiter_if #(.AW(32), .DW(32)) mem ();

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT    (8)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .iready    (iready),
        .irdata    (irdata),
        .dreq      (dreq),
        .dwe       (dwe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dready    (dready),
        .drdata    (drdata),
        .mem       (mem),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dcount;
        int fetches;
        int runs [2];
        int bad_mreq;
        int bad_ready;

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0;
        mem.mack = 1'b0; mem.mrdata = '0;
        repeat (3) tick();
        #1;
        check("rst_mreq", {31'b0, mem.mreq}, 32'h0);
        check("rst_mwe", {31'b0, mem.mwe}, 32'h0);
        check("rst_maddr", mem.maddr, 32'h0);
        check("rst_mwdata", mem.mwdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        reset = 1'b1;

        // Lone fetch; the requester moves iaddr mid-transaction.
        tick(); ireq = 1'b1; iaddr = 32'h40; #1;
        check("f_c0_mreq", {31'b0, mem.mreq}, 32'h0);
        check("f_c0_stall", {31'b0, stall_if}, 32'h1);
        tick(); #1;
        check("f_c1_mreq", {31'b0, mem.mreq}, 32'h1);
        check("f_c1_maddr", mem.maddr, 32'h40);
        check("f_c1_mwe", {31'b0, mem.mwe}, 32'h0);
        tick(); iaddr = 32'h44; #1;
        check("f_c2_maddr", mem.maddr, 32'h40);
        check("f_c2_stall", {31'b0, stall_if}, 32'h1);
        tick(); mem.mack = 1'b1; mem.mrdata = 32'h8C02_0004; #1;
        check("f_c3_iready", {31'b0, iready}, 32'h1);
        check("f_c3_irdata", irdata, 32'h8C02_0004);
        check("f_c3_maddr", mem.maddr, 32'h40);
        check("f_c3_stall", {31'b0, stall_if}, 32'h0);
        tick(); mem.mack = 1'b0; ireq = 1'b0; #1;
        check("f_c4_mreq", {31'b0, mem.mreq}, 32'h0);

        // Simultaneous requests: store wins, bubble, then fetch.
        tick();
        ireq = 1'b1; iaddr = 32'h80;
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF; #1;
        check("s_c0_stallmem", {31'b0, stall_mem}, 32'h1);
        tick(); #1;
        check("s_c1_mreq", {31'b0, mem.mreq}, 32'h1);
        check("s_c1_mwe", {31'b0, mem.mwe}, 32'h1);
        check("s_c1_maddr", mem.maddr, 32'h100);
        check("s_c1_mwdata", mem.mwdata, 32'hDEAD_BEEF);
        tick(); mem.mack = 1'b1; mem.mrdata = 32'h11; #1;
        check("s_c2_dready", {31'b0, dready}, 32'h1);
        check("s_c2_iready", {31'b0, iready}, 32'h0);
        tick(); mem.mack = 1'b0; dreq = 1'b0; #1;
        check("s_c3_bubble", {31'b0, mem.mreq}, 32'h0);
        check("s_c3_stallif", {31'b0, stall_if}, 32'h1);
        tick(); #1;
        check("s_c4_mreq", {31'b0, mem.mreq}, 32'h1);
        check("s_c4_maddr", mem.maddr, 32'h80);
        check("s_c4_mwe", {31'b0, mem.mwe}, 32'h0);
        tick(); mem.mack = 1'b1; mem.mrdata = 32'h22; #1;
        check("s_c5_iready", {31'b0, iready}, 32'h1);
        check("s_c5_irdata", irdata, 32'h22);
        tick(); mem.mack = 1'b0; ireq = 1'b0; #1;
        check("s_c6_mreq", {31'b0, mem.mreq}, 32'h0);

        // Starvation: both held, memory acks every busy cycle.
        ireq = 1'b1; iaddr = 32'h200;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h300;
        mem.mrdata = 32'h5A5A;
        dcount = 0; fetches = 0; runs[0] = -1; runs[1] = -1;
        for (int c = 0; c < 40 && fetches < 2; c++) begin
            tick(); mem.mack = mem.mreq; #1;
            if (dready) dcount++;
            if (iready) begin
                check("starve_iaddr", mem.maddr, 32'h200);
                runs[fetches] = dcount;
                dcount = 0;
                fetches++;
            end
        end
        check("starve_fetches", fetches, 32'd2);
        check("starve_run0", runs[0], 32'd4);
        check("starve_run1", runs[1], 32'd4);
        tick(); mem.mack = 1'b0; ireq = 1'b0; dreq = 1'b0; #1;
        tick(); #1;
        check("starve_idle", {31'b0, mem.mreq}, 32'h0);

        // Reset held low three cycles mid-DBUSY; a late mack must be ignored.
        tick(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h500; dwdata = 32'hCAFE_F00D; #1;
        tick(); #1;
        check("r_c1_mreq", {31'b0, mem.mreq}, 32'h1);
        tick(); reset = 1'b0; #1;
        check("r_c2_mreq", {31'b0, mem.mreq}, 32'h1);
        tick(); mem.mack = 1'b1; #1;
        check("r_c3_mreq", {31'b0, mem.mreq}, 32'h0);
        check("r_c3_dready", {31'b0, dready}, 32'h0);
        tick(); mem.mack = 1'b0; #1;
        tick(); reset = 1'b1; dreq = 1'b0; dwe = 1'b0; #1;
        check("r_c5_maddr", mem.maddr, 32'h0);
        check("r_c5_mwdata", mem.mwdata, 32'h0);
        check("r_c5_mwe", {31'b0, mem.mwe}, 32'h0);
        tick(); mem.mack = 1'b1; #1;
        check("r_c6_dready", {31'b0, dready}, 32'h0);
        check("r_c6_iready", {31'b0, iready}, 32'h0);
        tick(); mem.mack = 1'b0; #1;
        check("r_c7_mreq", {31'b0, mem.mreq}, 32'h0);
        check("r_c7_err", {31'b0, err}, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Data request that the memory never acknowledges.
        bad_ready = 0;
        tick(); dreq = 1'b1; dwe = 1'b0; daddr = 32'h600; #1;
        for (int c = 1; c <= 8; c++) begin
            tick(); #1;
            if (dready) bad_ready++;
            if (!mem.mreq) bad_ready++;
        end
        check("to_c8_err", {31'b0, err}, 32'h0);
        tick(); #1;
        check("to_c9_err", {31'b0, err}, 32'h1);
        check("to_c9_mreq", {31'b0, mem.mreq}, 32'h0);
        bad_mreq = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); ireq = 1'b1; iaddr = 32'h700; #1;
            if (mem.mreq) bad_mreq++;
            if (dready || iready) bad_ready++;
            if (!err) bad_mreq++;
        end
        check("to_nogrant", bad_mreq, 32'd0);
        check("to_noready", bad_ready, 32'd0);
        tick(); reset = 1'b0; ireq = 1'b0; dreq = 1'b0; #1;
        tick(); reset = 1'b1; #1;
        check("to_rst_err", {31'b0, err}, 32'h0);
`else
        bad_mreq = 0;
        bad_ready = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
